seven_seg_capture: RTL
======================

# seven_seg_capture

Reads a time-multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode lines) and reconstructs the hexadecimal value being shown. Each digit slot is qualified by a stability filter, then mapped from segment pattern back to a nibble. Once every digit has been captured, the block presents the assembled frame over a valid/ready handshake. It sits on the probe/loopback side of the display path and checks what the display driver actually emits.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (anode lines); range 1..8.
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a digit is captured; range 2..255.

- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment lines, active low; bit 0 = segment a … bit 6 = segment g; asynchronous to clk.
- an_in  in  NUM_DIGITS  anode selects, active low; bit i low selects digit i; asynchronous to clk.
- frame_ready  in  1  consumer accepts the frame on an edge where frame_valid=1.
- frame_valid  out  1  assembled frame is held on value/digit_err.
- value  out  4*NUM_DIGITS  digit i occupies value[4i+3:4i].
- digit_err  out  NUM_DIGITS  bit i = digit i pattern was not a legal hex glyph.
- overrun  out  1  sticky; a completed frame was dropped because the output was still held.

## Operation
- Synchronizer: 2-flop on seg_in and an_in. Reset value is all ones, which is idle.
- Anode qualification: the synchronized an is valid only when exactly one bit is low. If no bit or several bits are low, the sample is idle: the run counter clears and nothing is captured.
- Run counter: counts consecutive edges with an identical synchronized {an, seg}. Any change restarts it at 1.
  - When the run reaches STABLE_CYCLES, the digit is captured exactly once.
  - A captured flag blocks recapture until {an, seg} changes.
  - The counter saturates.
- Glyph decode, pattern → nibble:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 1111001 is 1 only, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0011000→9.
  - 0001000→A, 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F.
  - Any other pattern, including blank 1111111, decodes to nibble 0 with error = 1.
- Capture writes the nibble to shadow[i], the error bit to shadow_err[i], and sets seen[i]. A repeat capture of the same digit before the frame completes overwrites it: latest wins.
- Frame completion, when seen is all ones:
  - If the output is free (frame_valid=0, or frame_ready=1 on that edge), the next edge loads shadow and shadow_err into value and digit_err, sets frame_valid, and clears seen.
  - Otherwise the frame is discarded, seen is cleared, and overrun is set.
- frame_valid falls on the edge where frame_valid=1 and frame_ready=1, unless a new frame loads on that same edge, in which case frame_valid stays 1. value and digit_err are stable while frame_valid=1.
- Output register state machine: EMPTY→FULL on load; FULL→EMPTY on accept without load; FULL→FULL on accept with load.

## Timing
- Reset (asynchronous, any cycle, including mid-frame) clears the following; outputs are valid immediately:
  - value=0, digit_err=0, frame_valid=0, overrun=0.
  - seen=0, run counter=0, captured flag=0.
  - synchronizer flops set to all ones (idle).
- Capture latency: with {an, seg} changing before edge 0 and then held, shadow updates at edge STABLE_CYCLES+2 (2 synchronizer edges plus STABLE_CYCLES stability edges).
- frame_valid rises 1 edge after the capture that completes seen.
- Pulses held for STABLE_CYCLES−1 or fewer synchronized samples are never captured.
- overrun stays set until reset.
- Throughput: at most 1 digit capture per STABLE_CYCLES edges.

## Test plan
- Normal frame with defaults: drive each digit for 10 cycles, in order an=1110/seg=0011001 (4), 1101/0110000 (3), 1011/0100100 (2), 0111/1111001 (1); frame_ready=1 → value=16'h1234, digit_err=0, frame_valid=1 for 1 cycle, 7 edges after digit 3 settles.
- Glitch rejection: a 3-cycle seg=0000000 pulse inside digit 0's slot, between stable 0010010 samples → digit 0 = 5, no capture of 8.
- Illegal glyph: digit 2 driven 1111111 and the other digits legal → digit_err=4'b0100, value[11:8]=0.
- Backpressure: frame_ready=0, two full frames sent → first frame is held unchanged, overrun=1; raising frame_ready → frame_valid falls next edge.
- Bad anode: an=1100 for 20 cycles → no capture, seen unchanged; a correct frame afterwards completes normally.
- Reset mid-frame: assert rst after 2 digits are captured → all outputs 0 immediately; the frame completes only after all 4 digits are captured again.

Source files
------------

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
// Decodes a time-multiplexed, active-low seven-segment bus back into the hex
// value the display is showing. It observes the bus and does not drive it.
//
// Ports:
//   clk          sole clock
//   rst          asynchronous, active-high reset
//   seg_in[6:0]  segment lines a..g (bit 0 = a), active low, asynchronous
//   an_in[N-1:0] digit anode selects, active low, asynchronous
//   frame_ready  consumer takes the frame on an edge where frame_valid=1
//   frame_valid  a complete frame is held on value/digit_err
//   value        digit i occupies value[4i+3:4i]
//   digit_err    bit i set when digit i's pattern was not a hex glyph
//   overrun      sticky; a completed frame was dropped while output was held
module seven_seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    overrun
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int KEY_W = NUM_DIGITS + 7;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  // Returns {err, nibble}; unknown patterns (blank included) give {1, 0}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'b1_0000;
    case (pat)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0011000: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
      default:    r = 5'b1_0000;
    endcase
    return r;
  endfunction

  // Two-flop synchronizers; all ones is the idle (nothing lit) state.
  logic [6:0]            seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      an_s1_q  <= '1;
      an_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an_in;
      an_s2_q  <= an_s1_q;
    end
  end

  // Stability filter state.
  logic [KEY_W-1:0]      key;
  logic [KEY_W-1:0]      last_key_q;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  captured_q, captured_d;
  logic [NUM_DIGITS-1:0] an_low;
  logic                  an_ok;
  logic                  key_same;
  logic                  capture;
  logic [NUM_DIGITS-1:0] cap_mask;
  logic [4:0]            cap_glyph;

  assign key      = {an_s2_q, seg_s2_q};
  assign an_low   = ~an_s2_q;
  // Exactly one selected digit: non-zero and a power of two.
  assign an_ok    = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
  assign key_same = (key == last_key_q);

  // The run that just reached the threshold is described by last_key_q, so
  // the capture takes its digit and pattern from there. A nonzero run implies
  // last_key_q carries exactly one low anode bit.
  assign capture   = (run_q == RUN_MAX) && !captured_q;
  assign cap_mask  = ~last_key_q[KEY_W-1:7];
  assign cap_glyph = decode_glyph(last_key_q[6:0]);

  always_comb begin
    run_d      = run_q;
    captured_d = captured_q;
    if (!an_ok) begin
      run_d      = '0;
      captured_d = 1'b0;
    end else if (key_same && (run_q != '0)) begin
      run_d      = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
      captured_d = captured_q | capture;
    end else begin
      run_d      = RUN_W'(1);
      captured_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_key_q <= '1;
      run_q      <= '0;
      captured_q <= 1'b0;
    end else begin
      last_key_q <= key;
      run_q      <= run_d;
      captured_q <= captured_d;
    end
  end

  // Shadow frame being assembled.
  logic [3:0]              shadow_q [NUM_DIGITS];
  logic                    shadow_err_q [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] shadow_flat;
  logic [NUM_DIGITS-1:0]   shadow_err_flat;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    complete;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_q[gi]     <= '0;
        shadow_err_q[gi] <= 1'b0;
      end else if (capture && cap_mask[gi]) begin
        shadow_q[gi]     <= cap_glyph[3:0];
        shadow_err_q[gi] <= cap_glyph[4];
      end
    end
    assign shadow_flat[4*gi +: 4] = shadow_q[gi];
    assign shadow_err_flat[gi]    = shadow_err_q[gi];
  end

  assign complete = &seen_q;

  // A completed frame always leaves the shadow (loaded or dropped); a capture
  // on that same edge starts the next frame.
  always_comb begin
    seen_d = complete ? '0 : seen_q;
    if (capture) begin
      seen_d = seen_d | cap_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= '0;
    end else begin
      seen_q <= seen_d;
    end
  end

  // Output register: holds a frame until accepted; loading is allowed on the
  // same edge as an accept.
  out_state_e              state_q;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   digit_err_q;
  logic                    overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OUT_EMPTY;
      value_q     <= '0;
      digit_err_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (complete) begin
        if ((state_q == OUT_EMPTY) || frame_ready) begin
          value_q     <= shadow_flat;
          digit_err_q <= shadow_err_flat;
          state_q     <= OUT_FULL;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if ((state_q == OUT_FULL) && frame_ready) begin
        state_q <= OUT_EMPTY;
      end
    end
  end

  assign frame_valid = (state_q == OUT_FULL);
  assign value       = value_q;
  assign digit_err   = digit_err_q;
  assign overrun     = overrun_q;

endmodule
